// File: rtl/prog_loader.sv
// prog_loader: boot loader that writes a length-prefixed, checksummed byte stream into
// instruction memory and holds the core in reset until the image is verified.
module prog_loader #(
    parameter int unsigned IMEM_WORDS  = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic        top_clk,
    input  logic        top_rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_rst,
    output logic        done,
    output logic        err
);
    localparam int WW = $clog2(IMEM_WORDS + 1);
    typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE, ERR} state_t;
    state_t        state, state_nx;
    logic [1:0]    bcnt;
    logic [31:0]   len, word, to_cnt, len_nx, word_nx;
    logic [WW-1:0] widx;
    logic [7:0]    csum;
    logic          busy, acc, to_hit, last_word;

    assign busy      = state inside {LEN, DATA, CSUM};
    // gated by reset so the loader never looks ready while held
    assign rx_ready  = top_rst_n & (busy | (state == IDLE));
    assign acc       = rx_valid & rx_ready;
    assign len_nx    = {rx_data, len[31:8]};
    assign word_nx   = {rx_data, word[31:8]};
    assign last_word = 32'(widx) == len - 32'd1;
    assign to_hit    = (TIMEOUT_CYC != 0) && busy && !acc && (to_cnt + 32'd1 == TIMEOUT_CYC);
    assign cpu_rst   = state != DONE;
    assign done      = state == DONE;
    assign err       = state == ERR;

    always_comb begin
        state_nx = state;
        if (to_hit)
            state_nx = ERR;
        else if (acc)
            case (state)
                IDLE:    state_nx = LEN;
                LEN:     state_nx = bcnt != 2'd3 ? LEN :
                                    (len_nx == 32'd0 || len_nx > IMEM_WORDS) ? ERR : DATA;
                DATA:    state_nx = (bcnt == 2'd3 && last_word) ? CSUM : DATA;
                CSUM:    state_nx = rx_data == csum ? DONE : ERR;
                default: state_nx = state;
            endcase
    end

    always_ff @(posedge top_clk or negedge top_rst_n)
        if (!top_rst_n)
            state <= IDLE;
        else
            state <= state_nx;

    always_ff @(posedge top_clk or negedge top_rst_n) begin
        if (!top_rst_n) begin
            bcnt       <= '0;
            len        <= '0;
            word       <= '0;
            to_cnt     <= '0;
            widx       <= '0;
            csum       <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= 1'b0;
            to_cnt  <= (acc || !busy) ? 32'd0 : to_cnt + 32'd1;
            if (acc && state != CSUM)
                bcnt <= bcnt + 2'd1;
            if (acc && state inside {IDLE, LEN})
                len <= len_nx;
            if (acc && state == DATA) begin
                word <= word_nx;
                csum <= csum + rx_data;
                if (bcnt == 2'd3) begin
                    imem_we    <= 1'b1;
                    imem_addr  <= BASE_ADDR + (32'(widx) << 2);
                    imem_wdata <= word_nx;
                    widx       <= widx + 1'b1;
                end
            end
        end
    end
endmodule
